bram_stream_reader: RTL and testbench

- Read-side initiator for a 2K x 9 synchronous dual-port block RAM port (8 data + 1 parity, 11-bit address, 1-cycle read latency).
- On a START command it reads LEN consecutive words from BASE and presents them as a valid/ready stream with full backpressure.
- Sits between a RAM port (WE held low) and a downstream stream consumer.
- Sustains 1 word/cycle through a 2-entry output buffer that absorbs read latency.

---
 rtl/bram_stream_reader.sv | 155 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Block-RAM read initiator: streams LEN words from BASE as valid/ready with a 2-entry latency buffer.
// Optional odd-parity checker on captured words, enabled by `define BRAM_RD_PARITY_CHK_EN.
module bram_stream_reader #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 12
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [ADDR_W-1:0] BASE,
   input  logic [LEN_W-1:0]  LEN,
   output logic              BUSY,
   output logic              DONE,
   output logic              RAM_EN,
   output logic              RAM_WE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   input  logic [DATA_W-1:0] RAM_DO,
   input  logic              RAM_DOP,
   output logic              M_VALID,
   input  logic              M_READY,
   output logic [DATA_W:0]   M_DATA,
   output logic              M_LAST,
   output logic              PAR_ERR
);

   localparam int unsigned WORD_W = DATA_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  issue_cnt_q;
   logic [LEN_W-1:0]  out_cnt_q;
   logic              inflight_q;
   logic [WORD_W-1:0] buf_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;
   logic              done_q;

   logic              issue;
   logic              load;
   logic              done_d;
   logic              pop;
   logic [2:0]        pending;

   // Words buffered plus in flight, net of a pop at this edge, bound the issue window.
   assign pop     = (count_q != 2'd0) && M_READY;
   assign pending = 3'(count_q) + 3'(inflight_q) - 3'(pop);

   always_ff @(posedge CLK) begin
      if (RST) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      load    = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               if (LEN != '0) begin
                  load    = 1'b1;
                  state_d = S_RUN;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (issue_cnt_q == '0) begin
               state_d = S_DRAIN;
            end else if (pending < 3'd2) begin
               issue = 1'b1;
               if (issue_cnt_q == LEN_W'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && (out_cnt_q == LEN_W'(1))) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A reset cycle must not launch a read.
      if (RST) issue = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q      <= '0;
         issue_cnt_q <= '0;
         out_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         done_q      <= 1'b0;
      end else begin
         done_q     <= done_d;
         inflight_q <= issue;
         if (load) begin
            addr_q      <= BASE;
            issue_cnt_q <= LEN;
            out_cnt_q   <= LEN;
         end else begin
            if (issue) begin
               addr_q      <= addr_q + ADDR_W'(1);
               issue_cnt_q <= issue_cnt_q - LEN_W'(1);
            end
            if (pop) out_cnt_q <= out_cnt_q - LEN_W'(1);
         end
         if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
         if (pop)        rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(inflight_q) - 2'(pop);
      end
   end

   // Capture RAM output one edge after the enabled read.
   always_ff @(posedge CLK) begin
      if (inflight_q) buf_q[wr_ptr_q] <= {RAM_DOP, RAM_DO};
   end

`ifdef BRAM_RD_PARITY_CHK_EN
   logic par_err_q;

   always_ff @(posedge CLK) begin
      if (RST)                                          par_err_q <= 1'b0;
      else if (inflight_q && !(^{RAM_DOP, RAM_DO}))    par_err_q <= 1'b1;
   end

   assign PAR_ERR = par_err_q;
`else
   assign PAR_ERR = 1'b0;
`endif

   assign BUSY     = (state_q != S_IDLE);
   assign DONE     = done_q;
   assign RAM_EN   = issue;
   assign RAM_WE   = 1'b0;
   assign RAM_ADDR = addr_q;
   assign M_VALID  = (count_q != 2'd0);
   assign M_DATA   = buf_q[rd_ptr_q];
   assign M_LAST   = (count_q != 2'd0) && (out_cnt_q == LEN_W'(1));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: RAM model, expected-word queue, negedge stream monitor.
module tb_bram_stream_reader;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned LEN_W  = 12;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
`ifdef BRAM_RD_PARITY_CHK_EN
   localparam bit PAR_EXP = 1'b1;
`else
   localparam bit PAR_EXP = 1'b0;
`endif

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              START = 1'b0;
   logic [ADDR_W-1:0] BASE = '0;
   logic [LEN_W-1:0]  LEN = '0;
   logic              BUSY;
   logic              DONE;
   logic              RAM_EN;
   logic              RAM_WE;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic [DATA_W-1:0] RAM_DO = '0;
   logic              RAM_DOP = 1'b0;
   logic              M_VALID;
   logic              M_READY = 1'b0;
   logic [DATA_W:0]   M_DATA;
   logic              M_LAST;
   logic              PAR_ERR;

   always #5 CLK = ~CLK;

   bram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .LEN(LEN),
      .BUSY(BUSY), .DONE(DONE), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE),
      .RAM_ADDR(RAM_ADDR), .RAM_DO(RAM_DO), .RAM_DOP(RAM_DOP),
      .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
      .M_LAST(M_LAST), .PAR_ERR(PAR_ERR)
   );

   // RAM model: one-cycle read latency, output held until the next enabled read.
   logic [DATA_W:0] mem [DEPTH];
   always @(posedge CLK) begin
      if (RAM_EN) begin
         RAM_DO  <= mem[RAM_ADDR][DATA_W-1:0];
         RAM_DOP <= mem[RAM_ADDR][DATA_W];
      end
   end

   int errors = 0;
   int checks = 0;
   int pops_done = 0;
   int out_model = 0;
   logic [DATA_W+1:0] sb_q [$];
   bit               prev_stall = 1'b0;
   logic [DATA_W:0]  prev_data = '0;
   logic             prev_last = 1'b0;
   logic [DATA_W+1:0] exp_word;
   bit               hs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Stream monitor: handshakes, stall stability and issue-window bound, sampled at negedge.
   task automatic monitor_step();
      if (RST) begin
         prev_stall = 1'b0;
         out_model  = 0;
      end else begin
         hs = M_VALID && M_READY;
         if (prev_stall) begin
            chk("stall_valid", M_VALID, 1);
            chk("stall_data", M_DATA, prev_data);
            chk("stall_last", M_LAST, prev_last);
         end
         if (RAM_EN) chk("ram_en_room", 32'((out_model - int'(hs)) < 2), 1);
         out_model = out_model + int'(RAM_EN) - int'(hs);
         if (hs) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL sb_unexpected: observed word 0x%0h expected no word", M_DATA);
            end else begin
               exp_word = sb_q.pop_front();
               chk("data", M_DATA, exp_word[DATA_W:0]);
               chk("last", M_LAST, exp_word[DATA_W+1]);
               pops_done++;
            end
         end
         prev_stall = M_VALID && !M_READY;
         prev_data  = M_DATA;
         prev_last  = M_LAST;
      end
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         monitor_step();
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no end of run, expected $finish before timeout");
      $fatal(1, "watchdog expired");
   end

   // Push expected words, then pulse START for one edge and scramble BASE/LEN afterwards.
   task automatic start_xfer(input logic [ADDR_W-1:0] base, input int len);
      for (int i = 0; i < len; i++) begin
         logic [ADDR_W-1:0] a;
         a = base + ADDR_W'(i);
         sb_q.push_back({1'(i == len - 1), mem[a]});
      end
      START = 1'b1;
      BASE  = base;
      LEN   = LEN_W'(len);
      @(posedge CLK); #1;
      START = 1'b0;
      BASE  = ADDR_W'($urandom);
      LEN   = LEN_W'($urandom);
   endtask

   // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
   task automatic wait_done(input string tag, input int mode, input int max_cyc, output int n);
      bit seen;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < max_cyc) begin
         M_READY = (mode == 0) ? 1'b1 : ((n % 3) == 0);
         @(negedge CLK);
         if (DONE === 1'b1) seen = 1'b1;
         else begin
            n++;
            @(posedge CLK); #1;
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 1);
   endtask

   task automatic end_checks(input string tag);
      chk({tag, "_busy_at_done"}, BUSY, 0);
      chk({tag, "_valid_at_done"}, M_VALID, 0);
      chk({tag, "_sb_empty"}, sb_q.size(), 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk({tag, "_done_pulse"}, DONE, 0);
      @(posedge CLK); #1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < int'(DEPTH); i++) begin
         logic [DATA_W-1:0] d;
         d = DATA_W'(i);
         mem[i] = {~^d, d};
      end
      mem[5][DATA_W] = ~mem[5][DATA_W];

      // Reset state
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_ram_en", RAM_EN, 0);
      chk("rst_ram_we", RAM_WE, 0);
      chk("rst_ram_addr", RAM_ADDR, 0);
      chk("rst_valid", M_VALID, 0);
      chk("rst_last", M_LAST, 0);
      chk("rst_par_err", PAR_ERR, 0);
      @(posedge CLK); #1;

      // Basic read with latency checks
      M_READY = 1'b1;
      start_xfer(11'h010, 4);
      @(negedge CLK);
      chk("basic_ram_en", RAM_EN, 1);
      chk("basic_ram_addr", RAM_ADDR, 32'h010);
      chk("basic_busy", BUSY, 1);
      chk("basic_valid_c0", M_VALID, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("basic_valid_c1", M_VALID, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("basic_valid_c2", M_VALID, 1);
      @(posedge CLK); #1;
      wait_done("basic", 0, 20, n);
      chk("basic_stream_cycles", n, 3);
      end_checks("basic");

      // Address wrap
      start_xfer(11'h7FE, 4);
      wait_done("wrap", 0, 30, n);
      end_checks("wrap");

      // Zero length
      start_xfer(11'h123, 0);
      @(negedge CLK);
      chk("zero_done", DONE, 1);
      chk("zero_busy", BUSY, 0);
      chk("zero_valid", M_VALID, 0);
      chk("zero_ram_en", RAM_EN, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("zero_done_pulse", DONE, 0);
      chk("zero_valid2", M_VALID, 0);
      @(posedge CLK); #1;

      // Backpressure
      start_xfer(11'h000, 8);
      wait_done("bp", 1, 100, n);
      end_checks("bp");
      chk("bp_par_err", PAR_ERR, 32'(PAR_EXP));

      // Reset mid-transfer
      M_READY   = 1'b1;
      pops_done = 0;
      start_xfer(11'h100, 16);
      for (int i = 0; i < 40 && pops_done < 3; i++) begin
         @(posedge CLK); #1;
      end
      M_READY = 1'b0;
      chk("mid_pops", pops_done, 3);
      repeat (4) begin
         @(posedge CLK); #1;
      end
      @(negedge CLK);
      chk("mid_busy", BUSY, 1);
      chk("mid_valid", M_VALID, 1);
      @(posedge CLK); #1;
      RST = 1'b1;
      sb_q.delete();
      @(negedge CLK);
      chk("mid_rst_ram_en", RAM_EN, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_done", DONE, 0);
      chk("mid_rst_ram_en2", RAM_EN, 0);
      chk("mid_rst_valid", M_VALID, 0);
      chk("mid_rst_last", M_LAST, 0);
      chk("mid_rst_par_err", PAR_ERR, 0);
      chk("mid_rst_ram_addr", RAM_ADDR, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("mid_rst_no_done", DONE, 0);
      @(posedge CLK); #1;
      M_READY = 1'b1;
      start_xfer(11'h020, 2);
      wait_done("mid_restart", 0, 20, n);
      end_checks("mid_restart");

      // START while busy is ignored
      start_xfer(11'h040, 6);
      @(posedge CLK); #1;
      START = 1'b1;
      BASE  = 11'h300;
      LEN   = LEN_W'(3);
      @(posedge CLK); #1;
      START = 1'b0;
      wait_done("busy_start", 0, 30, n);
      end_checks("busy_start");

      // Parity error on word at address 5
      start_xfer(11'h004, 3);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("par_before", PAR_ERR, 0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("par_at_capture", PAR_ERR, 32'(PAR_EXP));
      @(posedge CLK); #1;
      wait_done("par", 0, 20, n);
      end_checks("par");
      chk("par_sticky", PAR_ERR, 32'(PAR_EXP));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
